// File: rtl/nios_onchip_memory_pipe_if.sv
// Avalon-MM style slave bus for the on-chip memory: request/data signals plus
// the clken/reset_req accept gates and the pipelined read response.
interface nios_onchip_memory_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    clken;
  logic                    reset_req;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_onchip_memory_pipe.sv
// Single-port on-chip RAM with byte-enabled writes and a 1- or 2-cycle read pipeline.
// Define NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN to add a zero-fill sweep after every reset.
module nios_onchip_memory_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_onchip_memory_pipe_if.slave  bus
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic                  clearing;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BYTES-1:0]  mem_be;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  readdatavalid_q, readdatavalid_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

`ifdef NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR && bus.clken) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {ADDR_WIDTH{1'b1}}) state_d = READY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clearing = (state_q == CLEAR);
`else
  assign clearing = 1'b0;
`endif

  assign bus.waitrequest = ~bus.clken | bus.reset_req | clearing;
  assign accept          = bus.chipselect & ~bus.waitrequest;
  assign wr_acc          = accept & bus.write;
  // A combined read+write is treated as a write only.
  assign rd_acc          = accept & bus.read & ~bus.write;

  always_comb begin
    mem_we    = wr_acc;
    mem_addr  = bus.address;
    mem_wdata = bus.writedata;
    mem_be    = bus.byteenable;
`ifdef NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN
    if (clearing) begin
      mem_we    = bus.clken;
      mem_addr  = clr_addr_q;
      mem_wdata = '0;
      mem_be    = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_be[b]) mem_array[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Data is captured at the accept edge, so later writes never disturb an in-flight read.
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    always_comb begin
      s1_valid_d = rd_acc;
      s1_data_d  = rd_acc ? mem_array[bus.address] : s1_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_acc;
    assign pipe_data  = mem_array[bus.address];
  end

  always_comb begin
    readdatavalid_d = pipe_valid;
    readdata_d      = pipe_valid ? pipe_data : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      readdatavalid_q <= readdatavalid_d;
      readdata_q      <= readdata_d;
    end
  end

  assign bus.readdatavalid = readdatavalid_q;
  assign bus.readdata      = readdata_q;
endmodule

// File: tb/tb_nios_onchip_memory_pipe.sv
// Directed bench: one shared stimulus drives a latency-1 and a latency-2 instance;
// with NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN a small 16-word instance exercises the sweep.
module tb_nios_onchip_memory_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, rd, wr, clken, reset_req;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  nios_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus1 ();
  nios_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

  assign bus1.address = addr;  assign bus2.address = addr;
  assign bus1.byteenable = be; assign bus2.byteenable = be;
  assign bus1.chipselect = cs; assign bus2.chipselect = cs;
  assign bus1.read = rd;       assign bus2.read = rd;
  assign bus1.write = wr;      assign bus2.write = wr;
  assign bus1.writedata = wdata; assign bus2.writedata = wdata;
  assign bus1.clken = clken;   assign bus2.clken = clken;
  assign bus1.reset_req = reset_req; assign bus2.reset_req = reset_req;

  nios_onchip_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1.slave));
  nios_onchip_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(rst_n), .bus(bus2.slave));

`ifdef NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN
  logic        c_rst_n, c_cs, c_rd, c_wr;
  logic [3:0]  c_addr;
  logic [31:0] c_wdata;
  nios_onchip_memory_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus3 ();
  assign bus3.address = c_addr;
  assign bus3.byteenable = 4'hF;
  assign bus3.chipselect = c_cs;
  assign bus3.read = c_rd;
  assign bus3.write = c_wr;
  assign bus3.writedata = c_wdata;
  assign bus3.clken = clken;
  assign bus3.reset_req = reset_req;
  nios_onchip_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1)) u_clr (
    .clk(clk), .reset_n(c_rst_n), .bus(bus3.slave));
  localparam logic [31:0] AFTER_RESET_10 = 32'h0;
`else
  localparam logic [31:0] AFTER_RESET_10 = 32'hDEADBEEF;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    cs = c; rd = r; wr = w; addr = a; wdata = d; be = b;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic writeWord(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d, b);
    step();
    idle();
  endtask

  // Latency-1 instance answers one edge after accept, latency-2 instance one edge later.
  task automatic readWord(input logic [7:0] a, input logic [31:0] expected, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    step();
    idle();
    checkOutput({tag, "_l1_valid"}, 32'(bus1.readdatavalid), 32'd1);
    checkOutput({tag, "_l1_data"}, bus1.readdata, expected);
    checkOutput({tag, "_l2_early"}, 32'(bus2.readdatavalid), 32'd0);
    step();
    checkOutput({tag, "_l1_pulse"}, 32'(bus1.readdatavalid), 32'd0);
    checkOutput({tag, "_l1_hold"}, bus1.readdata, expected);
    checkOutput({tag, "_l2_valid"}, 32'(bus2.readdatavalid), 32'd1);
    checkOutput({tag, "_l2_data"}, bus2.readdata, expected);
    step();
    checkOutput({tag, "_l2_pulse"}, 32'(bus2.readdatavalid), 32'd0);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while ((bus1.waitrequest || bus2.waitrequest) && n < 400) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(bus1.waitrequest | bus2.waitrequest), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle();
`ifdef NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN
    c_rst_n = 1'b0; c_cs = 1'b0; c_rd = 1'b0; c_wr = 1'b0; c_addr = 4'h0; c_wdata = 32'h0;
`endif
    step(); step();
    checkOutput("rst_l1_valid", 32'(bus1.readdatavalid), 32'd0);
    checkOutput("rst_l1_data", bus1.readdata, 32'h0);
    checkOutput("rst_l2_valid", 32'(bus2.readdatavalid), 32'd0);
    checkOutput("rst_l2_data", bus2.readdata, 32'h0);
    rst_n = 1'b1;
    waitReady("ready_after_reset");

    writeWord(8'h10, 32'hDEADBEEF, 4'hF);
    readWord(8'h10, 32'hDEADBEEF, "full_word");

    writeWord(8'h20, 32'h11223344, 4'hF);
    writeWord(8'h20, 32'hAABBCCDD, 4'h5);
    readWord(8'h20, 32'h11BB33DD, "byte_enable");

    writeWord(8'h01, 32'hA, 4'hF);
    writeWord(8'h02, 32'hB, 4'hF);
    writeWord(8'h03, 32'hC, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
    checkOutput("b2b_l1_d0", bus1.readdata, 32'hA);
    checkOutput("b2b_l2_v0", 32'(bus2.readdatavalid), 32'd0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 4'h0);
    checkOutput("b2b_l1_d1", bus1.readdata, 32'hB);
    checkOutput("b2b_l2_v1", 32'(bus2.readdatavalid), 32'd1);
    checkOutput("b2b_l2_d1", bus2.readdata, 32'hA);
    step();
    idle();
    checkOutput("b2b_l1_d2", bus1.readdata, 32'hC);
    checkOutput("b2b_l2_v2", 32'(bus2.readdatavalid), 32'd1);
    checkOutput("b2b_l2_d2", bus2.readdata, 32'hB);
    step();
    checkOutput("b2b_l1_v3", 32'(bus1.readdatavalid), 32'd0);
    checkOutput("b2b_l2_v3", 32'(bus2.readdatavalid), 32'd1);
    checkOutput("b2b_l2_d3", bus2.readdata, 32'hC);
    step();
    checkOutput("b2b_l2_v4", 32'(bus2.readdatavalid), 32'd0);

    writeWord(8'h40, 32'h12345678, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
    step();
    clken = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF);
    #1;
    checkOutput("clken_wait", 32'(bus1.waitrequest), 32'd1);
    checkOutput("clken_l1_data", bus1.readdata, 32'h12345678);
    checkOutput("clken_l1_valid", 32'(bus1.readdatavalid), 32'd1);
    step();
    checkOutput("clken_l2_valid", 32'(bus2.readdatavalid), 32'd1);
    checkOutput("clken_l2_data", bus2.readdata, 32'h12345678);
    step();
    clken = 1'b1;
    reset_req = 1'b1;
    #1;
    checkOutput("rstreq_wait", 32'(bus2.waitrequest), 32'd1);
    step();
    reset_req = 1'b0;
    idle();
    readWord(8'h40, 32'h12345678, "blocked_write");

    writeWord(8'h30, 32'h5, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 32'h9, 4'hF);
    step();
    idle();
    checkOutput("rdwr_l1_valid", 32'(bus1.readdatavalid), 32'd0);
    step();
    checkOutput("rdwr_l2_valid", 32'(bus2.readdatavalid), 32'd0);
    readWord(8'h30, 32'h9, "rdwr_after");

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_l2_valid", 32'(bus2.readdatavalid), 32'd0);
    checkOutput("midrst_l1_data", bus1.readdata, 32'h0);
    step();
    rst_n = 1'b1;
    checkOutput("midrst_l2_late", 32'(bus2.readdatavalid), 32'd0);
    step();
    checkOutput("midrst_l2_none", 32'(bus2.readdatavalid), 32'd0);
    waitReady("ready_after_midrst");
    readWord(8'h10, AFTER_RESET_10, "after_reset");

`ifdef NIOS_ONCHIP_MEMORY_PIPE_CLEAR_EN
    begin
      int n;
      step();
      c_rst_n = 1'b1;
      n = 0;
      while (bus3.waitrequest && n < 40) begin n++; step(); end
      checkOutput("clr_sweep1", 32'(n), 32'd16);
      c_cs = 1'b1; c_wr = 1'b1; c_addr = 4'h5; c_wdata = 32'hFFFFFFFF;
      step();
      c_addr = 4'hF;
      step();
      c_wr = 1'b0; c_rd = 1'b1; c_addr = 4'h5;
      step();
      c_cs = 1'b0; c_rd = 1'b0;
      checkOutput("clr_prefill", bus3.readdata, 32'hFFFFFFFF);
      c_rst_n = 1'b0;
      step();
      c_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      checkOutput("clr_mid_wait", 32'(bus3.waitrequest), 32'd1);
      c_rst_n = 1'b0;
      step();
      c_rst_n = 1'b1;
      n = 0;
      while (bus3.waitrequest && n < 40) begin n++; step(); end
      checkOutput("clr_sweep2", 32'(n), 32'd16);
      for (int i = 0; i < 16; i++) begin
        c_cs = 1'b1; c_rd = 1'b1; c_addr = 4'(i);
        step();
        c_cs = 1'b0; c_rd = 1'b0;
        checkOutput($sformatf("clr_valid_%0d", i), 32'(bus3.readdatavalid), 32'd1);
        checkOutput($sformatf("clr_zero_%0d", i), bus3.readdata, 32'h0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
